// File: rtl/tb_ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// tb_ram_arb_pkg: shared types and limits for the testbench RAM port arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tb_ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam int MAX_MEM_LATENCY = 4;

endpackage

`default_nettype wire

// File: rtl/tb_ram_arb_owner_pipe.sv
// ----------------------------------------------------------------------------
// tb_ram_arb_owner_pipe: DEPTH-stage shift register tagging each RAM slot with its owner.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ram_arb_owner_pipe
  import tb_ram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  owner_e i_owner,
  output owner_e o_owner
);

  localparam int c_pipe_width = 2 * DEPTH;

  logic [c_pipe_width-1:0] r_shift;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_shift <= OWN_NONE;
      end else begin
        r_shift <= i_owner;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_shift <= {DEPTH{OWN_NONE}};
      end else begin
        r_shift <= {r_shift[c_pipe_width-3:0], i_owner};
      end
    end
  end

  // Oldest entry sits in the top two bits.
  assign o_owner = owner_e'(r_shift[c_pipe_width-1 -: 2]);

endmodule

`default_nettype wire

// File: rtl/tb_ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_port_arbiter: round-robin share of one fixed-latency RAM port between OBI instr/data ports.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ram_port_arbiter
  import tb_ram_arb_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 20,
  parameter int MEM_LATENCY    = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      instr_req_i,
  input  logic [31:0]               instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [31:0]               instr_rdata_o,
  input  logic                      data_req_i,
  input  logic [31:0]               data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [31:0]               data_wdata_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [31:0]               data_rdata_o,
  output logic                      mem_req_o,
  output logic [RAM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i,
  output logic [CNT_WIDTH-1:0]      instr_gnt_cnt_o,
  output logic [CNT_WIDTH-1:0]      data_gnt_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_bad_latency
    $error("tb_ram_port_arbiter: MEM_LATENCY must lie in 1..%0d", MAX_MEM_LATENCY);
  end

  if (RAM_ADDR_WIDTH < 32) begin : g_addr_trunc
    logic w_unused_addr;
    assign w_unused_addr = ^{instr_addr_i[31:RAM_ADDR_WIDTH], data_addr_i[31:RAM_ADDR_WIDTH]};
  end

  owner_e               r_last_grant;
  owner_e               w_owner_in;
  owner_e               w_owner_tap;
  logic                 w_instr_gnt;
  logic                 w_data_gnt;
  logic [CNT_WIDTH-1:0] r_instr_cnt;
  logic [CNT_WIDTH-1:0] r_data_cnt;

  // Requests seen while reset is held are never granted.
  always_comb begin
    w_instr_gnt = 1'b0;
    w_data_gnt  = 1'b0;
    if (!rst_i) begin
      if (instr_req_i && (!data_req_i || r_last_grant == OWN_DATA)) begin
        w_instr_gnt = 1'b1;
      end else if (data_req_i) begin
        w_data_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = 32'h0;
    if (w_instr_gnt) begin
      mem_addr_o = instr_addr_i[RAM_ADDR_WIDTH-1:0];
      mem_be_o   = 4'hF;
    end else if (w_data_gnt) begin
      mem_addr_o  = data_addr_i[RAM_ADDR_WIDTH-1:0];
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o = w_instr_gnt;
  assign data_gnt_o  = w_data_gnt;
  assign mem_req_o   = w_instr_gnt | w_data_gnt;

  // Reset to DATA so the first contended cycle goes to the instruction port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_grant <= OWN_DATA;
    end else if (w_instr_gnt) begin
      r_last_grant <= OWN_INSTR;
    end else if (w_data_gnt) begin
      r_last_grant <= OWN_DATA;
    end
  end

  assign w_owner_in = w_instr_gnt ? OWN_INSTR : (w_data_gnt ? OWN_DATA : OWN_NONE);

  tb_ram_arb_owner_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_owner_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_owner (w_owner_in),
    .o_owner (w_owner_tap)
  );

  assign instr_rvalid_o = (w_owner_tap == OWN_INSTR);
  assign data_rvalid_o  = (w_owner_tap == OWN_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instr_cnt <= '0;
      r_data_cnt  <= '0;
    end else begin
      if (w_instr_gnt && !(&r_instr_cnt)) begin
        r_instr_cnt <= r_instr_cnt + c_cnt_one;
      end
      if (w_data_gnt && !(&r_data_cnt)) begin
        r_data_cnt <= r_data_cnt + c_cnt_one;
      end
    end
  end

  assign instr_gnt_cnt_o = r_instr_cnt;
  assign data_gnt_cnt_o  = r_data_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tb_ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tb_ram_port_arbiter: drives two arbiter instances (latency 1 / 4-bit counters, latency 3 / 32-bit).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tb_ram_port_arbiter;
  import tb_ram_arb_pkg::*;

  localparam int AW    = 20;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int CW_A  = 4;
  localparam int CW_B  = 32;

  typedef struct {
    int          port;
    logic [31:0] data;
    bit          rd;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq, dreq, dwe;
  logic [31:0] iaddr, daddr, dwdata;
  logic [3:0]  dbe;

  logic            igt_a, irv_a, dgt_a, drv_a, mreq_a, mwe_a;
  logic [31:0]     ird_a, drd_a, mwd_a, mrd_a;
  logic [AW-1:0]   maddr_a;
  logic [3:0]      mbe_a;
  logic [CW_A-1:0] icnt_a, dcnt_a;
  logic            igt_b, irv_b, dgt_b, drv_b, mreq_b, mwe_b;
  logic [31:0]     ird_b, drd_b, mwd_b, mrd_b;
  logic [AW-1:0]   maddr_b;
  logic [3:0]      mbe_b;
  logic [CW_B-1:0] icnt_b, dcnt_b;

  always #5 clk = ~clk;

  tb_ram_port_arbiter #(.RAM_ADDR_WIDTH(AW), .MEM_LATENCY(LAT_A), .CNT_WIDTH(CW_A)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(igt_a),
    .instr_rvalid_o(irv_a), .instr_rdata_o(ird_a),
    .data_req_i(dreq), .data_addr_i(daddr), .data_we_i(dwe), .data_be_i(dbe),
    .data_wdata_i(dwdata), .data_gnt_o(dgt_a), .data_rvalid_o(drv_a), .data_rdata_o(drd_a),
    .mem_req_o(mreq_a), .mem_addr_o(maddr_a), .mem_we_o(mwe_a), .mem_be_o(mbe_a),
    .mem_wdata_o(mwd_a), .mem_rdata_i(mrd_a),
    .instr_gnt_cnt_o(icnt_a), .data_gnt_cnt_o(dcnt_a));

  tb_ram_port_arbiter #(.RAM_ADDR_WIDTH(AW), .MEM_LATENCY(LAT_B), .CNT_WIDTH(CW_B)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(igt_b),
    .instr_rvalid_o(irv_b), .instr_rdata_o(ird_b),
    .data_req_i(dreq), .data_addr_i(daddr), .data_we_i(dwe), .data_be_i(dbe),
    .data_wdata_i(dwdata), .data_gnt_o(dgt_b), .data_rvalid_o(drv_b), .data_rdata_o(drd_b),
    .mem_req_o(mreq_b), .mem_addr_o(maddr_b), .mem_we_o(mwe_b), .mem_be_o(mbe_b),
    .mem_wdata_o(mwd_b), .mem_rdata_i(mrd_b),
    .instr_gnt_cnt_o(icnt_b), .data_gnt_cnt_o(dcnt_b));

  function automatic logic [31:0] init_word(input logic [11:0] idx);
    return ({20'h0, idx} * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (wd & m);
  endfunction

  // Environment RAMs: one per instance, each with its own read latency.
  bit [31:0]   ram_a [4096];
  bit          ram_a_v [4096];
  bit [31:0]   ram_b [4096];
  bit          ram_b_v [4096];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  function automatic logic [31:0] rd_a(input logic [11:0] i);
    return ram_a_v[i] ? ram_a[i] : init_word(i);
  endfunction
  function automatic logic [31:0] rd_b(input logic [11:0] i);
    return ram_b_v[i] ? ram_b[i] : init_word(i);
  endfunction

  always @(posedge clk) begin
    if (mreq_a && mwe_a) begin
      ram_a[maddr_a[13:2]]   <= merge(rd_a(maddr_a[13:2]), mwd_a, mbe_a);
      ram_a_v[maddr_a[13:2]] <= 1'b1;
    end
    pipe_a <= mreq_a ? rd_a(maddr_a[13:2]) : 32'h0;
    if (mreq_b && mwe_b) begin
      ram_b[maddr_b[13:2]]   <= merge(rd_b(maddr_b[13:2]), mwd_b, mbe_b);
      ram_b_v[maddr_b[13:2]] <= 1'b1;
    end
    pipe_b[0] <= mreq_b ? rd_b(maddr_b[13:2]) : 32'h0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mrd_a = pipe_a;
  assign mrd_b = pipe_b[2];

  // Reference model: arbitration rule, memory contents, responses keyed by due cycle.
  bit [31:0] ref_mem [4096];
  bit        ref_v [4096];
  owner_e    m_last;
  int        m_cyc, m_icnt, m_dcnt;
  rsp_t      rsp_a [int];
  rsp_t      rsp_b [int];
  bit        e_gi, e_gd;
  int        total, bad;

  logic [125:0] act_a, act_b, exp_a, exp_b, msk_a, msk_b;
  assign act_a = {igt_a, dgt_a, mreq_a, maddr_a, mwe_a, mbe_a, mwd_a, irv_a, ird_a, drv_a, drd_a};
  assign act_b = {igt_b, dgt_b, mreq_b, maddr_b, mwe_b, mbe_b, mwd_b, irv_b, ird_b, drv_b, drd_b};

  function automatic logic [31:0] ref_rd(input logic [11:0] i);
    return ref_v[i] ? ref_mem[i] : init_word(i);
  endfunction

  function automatic void mk_exp(input rsp_t r, output logic [125:0] e, output logic [125:0] m);
    logic [AW-1:0] ma;
    logic          mw, irv, drv;
    logic [3:0]    mb;
    logic [31:0]   md;
    ma = '0; mw = 1'b0; mb = 4'h0; md = 32'h0;
    if (e_gi) begin
      ma = iaddr[AW-1:0]; mb = 4'hF;
    end else if (e_gd) begin
      ma = daddr[AW-1:0]; mw = dwe; mb = dbe; md = dwdata;
    end
    irv = (r.port == 1);
    drv = (r.port == 2);
    e = {e_gi, e_gd, e_gi | e_gd, ma, mw, mb, md,
         irv, irv ? r.data : 32'h0, drv, (drv && r.rd) ? r.data : 32'h0};
    m = '1;
    if (drv && !r.rd) m[31:0] = 32'h0;
  endfunction

  task automatic apply(input bit r, input bit ir, input logic [31:0] ia, input bit dr,
                       input logic [31:0] da, input bit we, input logic [3:0] be,
                       input logic [31:0] wd);
    rsp_t ra, rb;
    rst = r; ireq = ir; iaddr = ia; dreq = dr; daddr = da; dwe = we; dbe = be; dwdata = wd;
    if (r) begin
      rsp_a.delete(); rsp_b.delete();
      m_last = OWN_DATA; m_icnt = 0; m_dcnt = 0;
    end
    e_gi = !r && ir && (!dr || m_last == OWN_DATA);
    e_gd = !r && dr && !e_gi;
    ra = '{0, 32'h0, 1'b0};
    rb = '{0, 32'h0, 1'b0};
    if (rsp_a.exists(m_cyc)) ra = rsp_a[m_cyc];
    if (rsp_b.exists(m_cyc)) rb = rsp_b[m_cyc];
    #4;
    mk_exp(ra, exp_a, msk_a);
    mk_exp(rb, exp_b, msk_b);
  endtask

  task automatic advance();
    rsp_t x;
    @(posedge clk);
    if (e_gi) begin
      x = '{1, ref_rd(iaddr[13:2]), 1'b1};
      rsp_a[m_cyc + LAT_A] = x; rsp_b[m_cyc + LAT_B] = x;
      m_last = OWN_INSTR; m_icnt++;
    end
    if (e_gd) begin
      x = '{2, ref_rd(daddr[13:2]), !dwe};
      rsp_a[m_cyc + LAT_A] = x; rsp_b[m_cyc + LAT_B] = x;
      if (dwe) begin
        ref_mem[daddr[13:2]] = merge(ref_rd(daddr[13:2]), dwdata, dbe);
        ref_v[daddr[13:2]]   = 1'b1;
      end
      m_last = OWN_DATA; m_dcnt++;
    end
    if (rsp_a.exists(m_cyc)) rsp_a.delete(m_cyc);
    if (rsp_b.exists(m_cyc)) rsp_b.delete(m_cyc);
    m_cyc++;
    #1;
  endtask

  task automatic idle(input bit r);
    apply(r, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic reset_cycle();
    idle(1'b1);
    advance();
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] r;
    r = $urandom;
    return {r[31:20], 6'h0, r[13:0]};
  endfunction

  task automatic test_reset();
    reset_cycle();
    apply(1'b1, 1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 4'hF, 32'h1234);
    if ((act_a & msk_a) !== exp_a) begin bad++; $display("FAIL reset_vec_a got=%h exp=%h", act_a, exp_a); end
    total++;
    if ((act_b & msk_b) !== exp_b) begin bad++; $display("FAIL reset_vec_b got=%h exp=%h", act_b, exp_b); end
    total++;
    if ({icnt_a, dcnt_a} !== 8'h0) begin bad++; $display("FAIL reset_cnt_a got=%h exp=0", {icnt_a, dcnt_a}); end
    total++;
    if ({icnt_b, dcnt_b} !== 64'h0) begin bad++; $display("FAIL reset_cnt_b got=%h exp=0", {icnt_b, dcnt_b}); end
    total++;
    advance();
  endtask

  task automatic test_single_fetch();
    reset_cycle();
    for (int k = 0; k < 5; k++) begin
      if (k == 0) apply(1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      else idle(1'b0);
      if ((act_a & msk_a) !== exp_a) begin bad++; $display("FAIL fetch_vec_a k=%0d got=%h exp=%h", k, act_a, exp_a); end
      total++;
      if ((act_b & msk_b) !== exp_b) begin bad++; $display("FAIL fetch_vec_b k=%0d got=%h exp=%h", k, act_b, exp_b); end
      total++;
      if (irv_a !== (k == 1)) begin bad++; $display("FAIL fetch_rvalid_a k=%0d got=%b exp=%b", k, irv_a, k == 1); end
      total++;
      advance();
    end
  endtask

  task automatic test_alternate();
    reset_cycle();
    for (int k = 0; k < 10; k++) begin
      if (k < 6) apply(1'b0, 1'b1, 32'h100 + 32'(4 * k), 1'b1, 32'h300 + 32'(4 * k), 1'b0, 4'hF, 32'h0);
      else idle(1'b0);
      if ((act_a & msk_a) !== exp_a) begin bad++; $display("FAIL alt_vec_a k=%0d got=%h exp=%h", k, act_a, exp_a); end
      total++;
      if ((act_b & msk_b) !== exp_b) begin bad++; $display("FAIL alt_vec_b k=%0d got=%h exp=%h", k, act_b, exp_b); end
      total++;
      if (k < 6 && {igt_a, dgt_a} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL alt_order k=%0d got=%b", k, {igt_a, dgt_a});
      end
      if (k < 6) total++;
      advance();
    end
    if ({icnt_a, dcnt_a} !== {4'd3, 4'd3}) begin bad++; $display("FAIL alt_cnt_a got=%h exp=33", {icnt_a, dcnt_a}); end
    total++;
    if (icnt_b !== 32'd3 || dcnt_b !== 32'd3) begin bad++; $display("FAIL alt_cnt_b got=%0d/%0d exp=3/3", icnt_b, dcnt_b); end
    total++;
  endtask

  task automatic test_write_fetch();
    reset_cycle();
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b1, 4'hF, 32'h0);
        1: apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        2: apply(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        default: idle(1'b0);
      endcase
      if ((act_a & msk_a) !== exp_a) begin bad++; $display("FAIL wr_vec_a k=%0d got=%h exp=%h", k, act_a, exp_a); end
      total++;
      if ((act_b & msk_b) !== exp_b) begin bad++; $display("FAIL wr_vec_b k=%0d got=%h exp=%h", k, act_b, exp_b); end
      total++;
      if (k == 1 && {mwe_a, mbe_a} !== 5'b1_0011) begin bad++; $display("FAIL wr_we_be got=%b exp=10011", {mwe_a, mbe_a}); end
      if (k == 1) total++;
      if (k == 3 && (irv_a !== 1'b1 || ird_a !== 32'h0000_BEEF)) begin
        bad++; $display("FAIL wr_fetch_data got=%b/%h exp=1/0000beef", irv_a, ird_a);
      end
      if (k == 3) total++;
      advance();
    end
  endtask

  task automatic test_latency3();
    int pulses, first, last;
    pulses = 0; first = -1; last = -1;
    reset_cycle();
    for (int k = 0; k < 9; k++) begin
      if (k < 4) apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h200 + 32'(4 * k), 1'b0, 4'hF, 32'h0);
      else idle(1'b0);
      if ((act_b & msk_b) !== exp_b) begin bad++; $display("FAIL lat3_vec_b k=%0d got=%h exp=%h", k, act_b, exp_b); end
      total++;
      if (drv_b) begin
        if (first < 0) first = k;
        last = k;
        pulses++;
      end
      advance();
    end
    if (pulses !== 4 || first !== 3 || last !== 6) begin
      bad++; $display("FAIL lat3_pulses got=%0d first=%0d last=%0d exp=4/3/6", pulses, first, last);
    end
    total++;
  endtask

  task automatic test_reset_inflight();
    reset_cycle();
    for (int k = 0; k < 9; k++) begin
      if (k < 2) apply(1'b0, 1'b1, 32'h40, 1'b1, 32'h44, 1'b0, 4'hF, 32'h0);
      else if (k < 4) apply(1'b1, 1'b1, 32'h40, 1'b1, 32'h44, 1'b0, 4'hF, 32'h0);
      else if (k < 8) idle(1'b0);
      else apply(1'b0, 1'b1, 32'h48, 1'b1, 32'h4C, 1'b0, 4'hF, 32'h0);
      if ((act_a & msk_a) !== exp_a) begin bad++; $display("FAIL rst_vec_a k=%0d got=%h exp=%h", k, act_a, exp_a); end
      total++;
      if ((act_b & msk_b) !== exp_b) begin bad++; $display("FAIL rst_vec_b k=%0d got=%h exp=%h", k, act_b, exp_b); end
      total++;
      if (k >= 2 && {irv_a, drv_a, irv_b, drv_b} !== 4'h0) begin
        bad++; $display("FAIL rst_stale_rvalid k=%0d got=%b", k, {irv_a, drv_a, irv_b, drv_b});
      end
      if (k >= 2) total++;
      if (k == 8 && {igt_a, dgt_a, igt_b, dgt_b} !== 4'b1010) begin
        bad++; $display("FAIL rst_first_grant got=%b exp=1010", {igt_a, dgt_a, igt_b, dgt_b});
      end
      if (k == 8) total++;
      advance();
    end
  endtask

  task automatic test_saturate();
    reset_cycle();
    for (int k = 0; k < 22; k++) begin
      if (k < 20) apply(1'b0, 1'b1, 32'h500 + 32'(4 * k), 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      else idle(1'b0);
      if ((act_a & msk_a) !== exp_a) begin bad++; $display("FAIL sat_vec_a k=%0d got=%h exp=%h", k, act_a, exp_a); end
      total++;
      advance();
    end
    if (icnt_a !== 4'hF) begin bad++; $display("FAIL sat_cnt_a got=%0d exp=15", icnt_a); end
    total++;
    if (icnt_b !== 32'd20) begin bad++; $display("FAIL sat_cnt_b got=%0d exp=20", icnt_b); end
    total++;
  endtask

  task automatic test_random();
    logic [31:0] r;
    int          sat_i, sat_d;
    reset_cycle();
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      apply(r[5:0] == 6'd0, r[7:6] != 2'b00, rnd_addr(), r[9:8] != 2'b00, rnd_addr(),
            r[10], r[14:11], $urandom);
      if ((act_a & msk_a) !== exp_a) begin bad++; $display("FAIL rnd_vec_a k=%0d got=%h exp=%h", k, act_a, exp_a); end
      total++;
      if ((act_b & msk_b) !== exp_b) begin bad++; $display("FAIL rnd_vec_b k=%0d got=%h exp=%h", k, act_b, exp_b); end
      total++;
      advance();
    end
    sat_i = (m_icnt > 15) ? 15 : m_icnt;
    sat_d = (m_dcnt > 15) ? 15 : m_dcnt;
    if (icnt_a !== 4'(sat_i) || dcnt_a !== 4'(sat_d)) begin
      bad++; $display("FAIL rnd_cnt_a got=%0d/%0d exp=%0d/%0d", icnt_a, dcnt_a, sat_i, sat_d);
    end
    total++;
    if (icnt_b !== 32'(m_icnt) || dcnt_b !== 32'(m_dcnt)) begin
      bad++; $display("FAIL rnd_cnt_b got=%0d/%0d exp=%0d/%0d", icnt_b, dcnt_b, m_icnt, m_dcnt);
    end
    total++;
  endtask

  initial begin
    total = 0; bad = 0; m_cyc = 0; m_icnt = 0; m_dcnt = 0; m_last = OWN_DATA;
    test_reset();
    test_single_fetch();
    test_alternate();
    test_write_fetch();
    test_latency3();
    test_reset_inflight();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tb_ram_port_arbiter.md
# tb_ram_port_arbiter

Testbench-side arbiter that shares one single-port, fixed-latency RAM port between the core's instruction and data OBI-style request/grant/rvalid interfaces. Sits between the core and the RAM in the CV32E40P testbench wrapper, where today the two core interfaces each have a dedicated memory port. Provides:
- round-robin arbitration;
- tracking of in-flight transactions so each response is returned to the port that issued it;
- saturating grant counters for bandwidth inspection.

## Interface
Parameters:
- RAM_ADDR_WIDTH, 20, byte-address bits forwarded to the RAM; upper address bits are dropped.
- MEM_LATENCY, 1, cycles from RAM request to RAM read data; legal range 1..4.
- CNT_WIDTH, 32, width of each grant counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_req_i  in  1  instruction fetch request.
- instr_addr_i  in  32  fetch byte address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch response data.
- data_req_i  in  1  data request.
- data_addr_i  in  32  data byte address.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  data request accepted this cycle.
- data_rvalid_o  out  1  data response valid; asserted for both reads and writes.
- data_rdata_o  out  32  read data.
- mem_req_o  out  1  RAM access this cycle.
- mem_addr_o  out  RAM_ADDR_WIDTH  RAM byte address.
- mem_we_o  out  1  RAM write enable.
- mem_be_o  out  4  RAM byte enables.
- mem_wdata_o  out  32  RAM write data.
- mem_rdata_i  in  32  RAM read data, valid MEM_LATENCY cycles after mem_req_o.
- instr_gnt_cnt_o  out  CNT_WIDTH  number of instruction grants, saturating.
- data_gnt_cnt_o  out  CNT_WIDTH  number of data grants, saturating.

## Operation
Arbitration:
- Grant is combinational, OBI-style: gnt is asserted in the same cycle as req. At most one port is granted per cycle.
- Only one port requesting: that port is granted.
- Both ports requesting: the port not granted most recently wins.
- Register last_grant records the most recently granted port; it updates only on a grant.

Memory request mux:
- mem_req_o = instr_gnt_o | data_gnt_o.
- Instruction grant: mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
- Data grant: we, be and wdata are driven from the data port.
- mem_addr_o = granted address[RAM_ADDR_WIDTH-1:0].
- No grant: all mem_* outputs are 0.

Response routing:
- An owner delay line of depth MEM_LATENCY shifts in {NONE, INSTR, DATA} every cycle.
- At the output tap, owner INSTR pulses instr_rvalid_o and owner DATA pulses data_rvalid_o.
- Both rdata outputs are driven by mem_rdata_i when their rvalid is high, and are 0 otherwise.
- A write still produces data_rvalid_o; data_rdata_o is the RAM output, which is don't-care for writes.

Counters:
- A counter increments on each grant to its port.
- It holds at all-ones (saturates) and never wraps.

## Timing
- Reset:
  - all outputs are 0;
  - owner pipe is all NONE;
  - last_grant = DATA, so an instruction fetch wins the first simultaneous request;
  - counters are 0.
- Latency: rvalid is asserted exactly MEM_LATENCY cycles after the grant cycle. Throughput is one grant per cycle.
- Back-to-back grants to one port are legal; responses return in grant order.
- Both requesting every cycle: grants alternate strictly I, D, I, D…
- Assertion of rst_i mid-operation:
  - in-flight responses are discarded;
  - no rvalid is issued for them after reset;
  - the first grant after reset follows the reset priority.
- Requests presented while rst_i is high are not granted.

## Structure
- Package tb_ram_arb_pkg holds:
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_INSTR, OWN_DATA};
  - constant MAX_MEM_LATENCY = 4.
- Sub-module tb_ram_arb_owner_pipe: the parameterized owner shift register of MEM_LATENCY stages of owner_e.
- An elaboration-time check rejects MEM_LATENCY outside 1..MAX_MEM_LATENCY.

## Test plan
- Reset then instr_req only, addr 0x80, MEM_LATENCY=1 -> instr_gnt_o same cycle; mem_addr_o=0x80, mem_be_o=F; instr_rvalid_o one cycle later with rdata = RAM[0x80].
- Both requesting every cycle for 6 cycles from reset -> grant order I,D,I,D,I,D; instr_gnt_cnt_o=3 and data_gnt_cnt_o=3; each rvalid appears on the matching port MEM_LATENCY cycles later.
- Data write of 0xDEADBEEF, be=4'b0011, to 0x1000, then instruction fetch of 0x1000 -> mem_we_o=1 and mem_be_o=3 on the write; fetch returns 0x0000BEEF; data_rvalid_o pulses for the write.
- MEM_LATENCY=3, four consecutive data reads -> four data_rvalid_o pulses in issue order, starting 3 cycles after the first grant, with no gaps.
- Assert rst_i while two responses are in flight -> no rvalid after reset; first simultaneous request after reset is granted to instr.
- CNT_WIDTH=4, 20 instruction grants -> instr_gnt_cnt_o holds at 15.
